// File: rtl/mem_port_arbiter.sv
// Two-requester (core / DMA) arbiter for a single memory port with one outstanding
// transaction, alternating priority on ties and a busy-cycle timeout.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_done,
   output logic          core_err,
   output logic [DW-1:0] core_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_done,
   output logic          dma_err,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY_CORE = 2'd1,
      BUSY_DMA  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

   state_t        state, state_next;
   logic [7:0]    count, count_next;
   logic          last_dma, last_dma_next;
   logic          re, re_next;
   logic          we, we_next;
   logic [AW-1:0] addr, addr_next;
   logic [DW-1:0] wdata, wdata_next;
   logic          done_core, done_core_next;
   logic          done_dma, done_dma_next;
   logic          err_core, err_core_next;
   logic          err_dma, err_dma_next;
   logic [DW-1:0] rdata_core, rdata_core_next;
   logic [DW-1:0] rdata_dma, rdata_dma_next;
   logic          grant_core, grant_dma;
   logic          owner_dma;

   // State and output registers; last_dma resets high so the core wins the first tie.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= IDLE;
         count      <= 8'd0;
         last_dma   <= 1'b1;
         re         <= 1'b0;
         we         <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         done_core  <= 1'b0;
         done_dma   <= 1'b0;
         err_core   <= 1'b0;
         err_dma    <= 1'b0;
         rdata_core <= '0;
         rdata_dma  <= '0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         last_dma   <= last_dma_next;
         re         <= re_next;
         we         <= we_next;
         addr       <= addr_next;
         wdata      <= wdata_next;
         done_core  <= done_core_next;
         done_dma   <= done_dma_next;
         err_core   <= err_core_next;
         err_dma    <= err_dma_next;
         rdata_core <= rdata_core_next;
         rdata_dma  <= rdata_dma_next;
      end
   end

   assign owner_dma = (state == BUSY_DMA);

   // Next-state logic: arbitration in IDLE, completion / timeout while busy.
   always_comb begin
      state_next      = state;
      count_next      = count;
      last_dma_next   = last_dma;
      re_next         = re;
      we_next         = we;
      addr_next       = addr;
      wdata_next      = wdata;
      done_core_next  = 1'b0;
      done_dma_next   = 1'b0;
      err_core_next   = 1'b0;
      err_dma_next    = 1'b0;
      rdata_core_next = '0;
      rdata_dma_next  = '0;
      grant_core      = 1'b0;
      grant_dma       = 1'b0;
      case (state)
         IDLE: begin
            if (core_req && (!dma_req || last_dma)) begin
               grant_core    = 1'b1;
               state_next    = BUSY_CORE;
               last_dma_next = 1'b0;
               count_next    = 8'd0;
               re_next       = ~core_we;
               we_next       = core_we;
               addr_next     = core_addr;
               wdata_next    = core_wdata;
            end else if (dma_req) begin
               grant_dma     = 1'b1;
               state_next    = BUSY_DMA;
               last_dma_next = 1'b1;
               count_next    = 8'd0;
               re_next       = ~dma_we;
               we_next       = dma_we;
               addr_next     = dma_addr;
               wdata_next    = dma_wdata;
            end else begin
               state_next = IDLE;
            end
         end
         BUSY_CORE, BUSY_DMA: begin
            // Ack takes precedence over a timeout landing in the same cycle.
            if (mem_ack) begin
               state_next = IDLE;
               re_next    = 1'b0;
               we_next    = 1'b0;
               if (owner_dma) begin
                  done_dma_next  = 1'b1;
                  rdata_dma_next = re ? mem_rdata : '0;
               end else begin
                  done_core_next  = 1'b1;
                  rdata_core_next = re ? mem_rdata : '0;
               end
            end else if (count == LAST_COUNT) begin
               state_next = IDLE;
               re_next    = 1'b0;
               we_next    = 1'b0;
               if (owner_dma) begin
                  done_dma_next = 1'b1;
                  err_dma_next  = 1'b1;
               end else begin
                  done_core_next = 1'b1;
                  err_core_next  = 1'b1;
               end
            end else begin
               count_next = count + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            re_next    = 1'b0;
            we_next    = 1'b0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted, before the reset edge lands.
   assign core_gnt   = resetn & grant_core;
   assign dma_gnt    = resetn & grant_dma;
   assign core_done  = resetn & done_core;
   assign dma_done   = resetn & done_dma;
   assign core_err   = resetn & err_core;
   assign dma_err    = resetn & err_dma;
   assign core_rdata = {DW{resetn}} & rdata_core;
   assign dma_rdata  = {DW{resetn}} & rdata_dma;
   assign mem_re     = resetn & re;
   assign mem_we     = resetn & we;
   assign mem_addr   = addr;
   assign mem_wdata  = wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TIMEOUT = 4;

   logic          clock = 1'b0;
   logic          resetn;
   logic          core_req, core_we, dma_req, dma_we;
   logic [AW-1:0] core_addr, dma_addr;
   logic [DW-1:0] core_wdata, dma_wdata;
   logic          core_gnt, core_done, core_err, dma_gnt, dma_done, dma_err;
   logic [DW-1:0] core_rdata, dma_rdata;
   logic          mem_re, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .resetn(resetn),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transfer, its busy-cycle age and pending done.
   bit            m_busy = 1'b0;
   bit            m_owner_dma, m_we, m_last_dma = 1'b1;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int            m_waited;
   bit            m_done_core = 1'b0, m_done_dma = 1'b0, m_err = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_win_core;

   assign m_win_core = core_req && (!dma_req || m_last_dma);

   always @(posedge clock) begin
      m_done_core <= 1'b0;
      m_done_dma  <= 1'b0;
      m_err       <= 1'b0;
      m_rdata     <= '0;
      if (!resetn) begin
         m_busy     <= 1'b0;
         m_last_dma <= 1'b1;
      end else if (m_busy) begin
         if (mem_ack || (m_waited + 1 == TIMEOUT)) begin
            m_busy <= 1'b0;
            if (m_owner_dma) m_done_dma <= 1'b1;
            else m_done_core <= 1'b1;
            m_err   <= !mem_ack;
            m_rdata <= (mem_ack && !m_we) ? mem_rdata : '0;
         end else begin
            m_waited <= m_waited + 1;
         end
      end else if (core_req || dma_req) begin
         m_busy      <= 1'b1;
         m_owner_dma <= !m_win_core;
         m_last_dma  <= !m_win_core;
         m_we        <= m_win_core ? core_we : dma_we;
         m_addr      <= m_win_core ? core_addr : dma_addr;
         m_wdata     <= m_win_core ? core_wdata : dma_wdata;
         m_waited    <= 0;
      end
   end

   // Every-cycle comparison of all outputs against the model, well away from the rising edge.
   always @(negedge clock) begin
      #2;
      chk("core_gnt", core_gnt, resetn && !m_busy && m_win_core);
      chk("dma_gnt", dma_gnt, resetn && !m_busy && dma_req && !m_win_core);
      chk("mem_re", mem_re, resetn && m_busy && !m_we);
      chk("mem_we", mem_we, resetn && m_busy && m_we);
      chk("one_strobe", mem_re & mem_we, 1'b0);
      chk("core_done", core_done, resetn && m_done_core);
      chk("dma_done", dma_done, resetn && m_done_dma);
      chk("core_err", core_err, resetn && m_done_core && m_err);
      chk("dma_err", dma_err, resetn && m_done_dma && m_err);
      chk("core_rdata", core_rdata, (resetn && m_done_core) ? m_rdata : '0);
      chk("dma_rdata", dma_rdata, (resetn && m_done_dma) ? m_rdata : '0);
      if (resetn && m_busy) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
   end

   task automatic cyc;
      @(negedge clock);
   endtask

   bit core_seen, dma_seen;

   initial begin
      resetn = 1'b0; core_req = 1'b1; dma_req = 1'b1; core_we = 1'b0; dma_we = 1'b0;
      core_addr = '0; dma_addr = '0; core_wdata = '0; dma_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      cyc; #1 chk("rst_core_gnt", core_gnt, 1'b0); chk("rst_dma_gnt", dma_gnt, 1'b0);
      cyc; core_req = 1'b0; dma_req = 1'b0;
      // Core read, ack on the third strobe cycle
      cyc; resetn = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0040;
      #1 chk("rd_gnt", core_gnt, 1'b1);
      cyc; core_req = 1'b0; #1 chk("rd_re", mem_re, 1'b1); chk("rd_addr", mem_addr, 32'h40);
      cyc;
      cyc; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1 chk("rd_re3", mem_re, 1'b1);
      cyc; mem_ack = 1'b0;
      #1 chk("rd_done", core_done, 1'b1); chk("rd_data", core_rdata, 32'hDEAD_BEEF);
      chk("rd_err", core_err, 1'b0); chk("rd_re_off", mem_re, 1'b0);
      // DMA write
      cyc; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h1234_5678;
      #1 chk("wr_gnt", dma_gnt, 1'b1);
      cyc; dma_req = 1'b0;
      #1 chk("wr_we", mem_we, 1'b1); chk("wr_wdata", mem_wdata, 32'h1234_5678);
      chk("wr_addr", mem_addr, 32'h80);
      cyc; mem_ack = 1'b1;
      cyc; mem_ack = 1'b0;
      #1 chk("wr_done", dma_done, 1'b1); chk("wr_err", dma_err, 1'b0); chk("wr_rdata", dma_rdata, 32'h0);
      // Tie: DMA was last, so the core wins; DMA grant coincides with core_done
      cyc; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h44;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h88; dma_wdata = 32'hA5A5_A5A5;
      #1 chk("tie_core", core_gnt, 1'b1); chk("tie_dma", dma_gnt, 1'b0);
      cyc; core_req = 1'b0; mem_ack = 1'b1; #1 chk("busy_no_gnt", dma_gnt, 1'b0);
      cyc; mem_ack = 1'b0; #1 chk("back2back_done", core_done, 1'b1); chk("back2back_gnt", dma_gnt, 1'b1);
      // DMA write with no ack: four strobe cycles then err
      cyc; dma_req = 1'b0;
      cyc; cyc; cyc; #1 chk("to_we4", mem_we, 1'b1);
      cyc; #1 chk("to_done", dma_done, 1'b1); chk("to_err", dma_err, 1'b1);
      chk("to_rdata", dma_rdata, 32'h0); chk("to_we_off", mem_we, 1'b0);
      // Stray ack in IDLE
      cyc; mem_ack = 1'b1;
      cyc; mem_ack = 1'b0; #1 chk("stray_core", core_done, 1'b0); chk("stray_dma", dma_done, 1'b0);
      // Reset during the second busy cycle of a core write
      cyc; core_req = 1'b1; core_we = 1'b1; core_addr = 32'h50; core_wdata = 32'h11;
      #1 chk("pre_rst_gnt", core_gnt, 1'b1);
      cyc; core_req = 1'b0;
      cyc; resetn = 1'b0;
      cyc; resetn = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h60;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h64;
      #1 chk("rst_we_off", mem_we, 1'b0); chk("rst_no_done", core_done, 1'b0);
      chk("rst_tie_core", core_gnt, 1'b1); chk("rst_tie_dma", dma_gnt, 1'b0);
      // Ack on the fourth busy cycle beats the timeout
      cyc; core_req = 1'b0;
      cyc; cyc;
      cyc; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      cyc; mem_ack = 1'b0;
      #1 chk("late_ack_done", core_done, 1'b1); chk("late_ack_err", core_err, 1'b0);
      chk("late_ack_data", core_rdata, 32'hCAFE_F00D); chk("late_ack_dma_gnt", dma_gnt, 1'b1);
      cyc; dma_req = 1'b0;
      core_seen = 1'b0; dma_seen = 1'b0;
      // Randomized traffic: requesters hold until granted, random ack latency and rare resets
      for (int i = 0; i < 3000; i++) begin
         cyc;
         resetn = ($urandom_range(0, 99) != 0);
         if (core_seen || !core_req) begin
            core_req = ($urandom_range(0, 2) != 0); core_we = 1'($urandom);
            core_addr = $urandom; core_wdata = $urandom;
         end
         if (dma_seen || !dma_req) begin
            dma_req = ($urandom_range(0, 2) != 0); dma_we = 1'($urandom);
            dma_addr = $urandom; dma_wdata = $urandom;
         end
         mem_ack = ($urandom_range(0, 3) == 0);
         mem_rdata = $urandom;
         #1 core_seen = core_gnt; dma_seen = dma_gnt;
      end
      cyc; core_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0; resetn = 1'b1;
      repeat (TIMEOUT + 3) cyc;
      #3 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter TIMEOUT, default 16, maximum number of busy cycles to wait for mem_ack, legal range 2..255.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 core_req / dma_req  input  1  level request from the core and from the DMA requester.
REQ-007 core_we / dma_we  input  1  1 = write, 0 = read.
REQ-008 core_addr / dma_addr  input  AW  word address.
REQ-009 core_wdata / dma_wdata  input  DW  write data.
REQ-010 core_gnt / dma_gnt  output  1  one-cycle pulse: the request was accepted this cycle.
REQ-011 core_done / dma_done  output  1  one-cycle pulse: the transaction has completed.
REQ-012 core_err / dma_err  output  1  qualifies done: the transaction timed out.
REQ-013 core_rdata / dma_rdata  output  DW  read data, valid while done is high and the transaction is a read.
REQ-014 mem_re / mem_we  output  1  memory read and write strobes.
REQ-015 mem_addr / mem_wdata  output  AW / DW  memory address and write data.
REQ-016 mem_rdata  input  DW  memory read data, sampled on the mem_ack cycle.
REQ-017 mem_ack  input  1  memory completion, variable latency of 1 or more cycles after the strobe rises.

Function
REQ-018 The arbiter SHALL implement states IDLE, BUSY_CORE and BUSY_DMA, with at most one transaction outstanding.
REQ-019 In IDLE, a request SHALL cause the grant to be asserted combinationally in that cycle (cycle N): a lone requester wins; on a tie the requester not granted last wins.
REQ-020 On the grant edge, the arbiter SHALL register the winner's we, addr and wdata and SHALL enter the matching BUSY state; mem_re or mem_we SHALL be high from cycle N+1.
REQ-021 A requester SHALL hold its req, we, addr and wdata stable until it sees its gnt; values after gnt SHALL be ignored.
REQ-022 While BUSY, the arbiter SHALL hold the strobe, mem_addr and mem_wdata constant and SHALL assert no gnt.
REQ-023 On the mem_ack cycle M, the arbiter SHALL capture mem_rdata, drop the strobe at M+1, and pulse the owner's done for the single cycle M+1 with err=0 and rdata equal to the captured data (0 for writes).
REQ-024 The state SHALL be IDLE at M+1, so a new grant is possible in M+1; one transaction therefore occupies latency+2 cycles.
REQ-025 A busy-cycle counter SHALL reset to 0 on entry to BUSY and increment each BUSY cycle without ack.
REQ-026 If the counter reaches TIMEOUT-1 without ack, the arbiter SHALL drop the strobe on the next edge, pulse done with err=1 and rdata=0, and return to IDLE.
REQ-027 If ack and timeout coincide in the same cycle, ack SHALL win and err SHALL be 0.
REQ-028 mem_ack SHALL be ignored in IDLE and in the done cycle.
REQ-029 The last-granted register SHALL update on every grant.
REQ-030 The non-owner's gnt, done, err and rdata SHALL be 0 at all times.
REQ-031 Both strobes SHALL never be high in the same cycle.
REQ-032 rdata SHALL be 0 whenever done is low.

Reset
REQ-033 While resetn=0, all gnt, done, err and strobes SHALL be 0, including gnt forced to 0 despite any req.
REQ-034 On reset the arbiter SHALL clear state to IDLE, the counter to 0, mem_addr, mem_wdata and all rdata to 0, and set last-granted to DMA so that the core wins the first tie.
REQ-035 Reset mid-transaction SHALL drop the strobes at the next edge and SHALL produce no done pulse for the aborted transaction.

Verification
REQ-036 Core read, ack after 2 cycles: core_req with addr 0x40 at cycle 0 -> core_gnt at cycle 0, mem_re cycles 1-3 with mem_addr 0x40, mem_rdata 0xDEADBEEF with ack at cycle 3 -> core_done and core_rdata 0xDEADBEEF at cycle 4.
REQ-037 Tie after reset: both requesting continuously -> grants alternate core, DMA, core, with DMA ahead of a core grant only when DMA was not granted last.
REQ-038 DMA write of 0x12345678 to 0x80 -> mem_we, mem_wdata 0x12345678 and mem_addr 0x80 held until ack; dma_done=1, dma_err=0, dma_rdata=0.
REQ-039 Timeout with TIMEOUT=4 and no ack -> strobe high for 4 cycles, then done with err=1, then IDLE; an ack on the 4th busy cycle -> err=0.
REQ-040 resetn low for 1 cycle in the 2nd busy cycle -> strobe 0 the next cycle, no done pulse, next tie granted to core.
REQ-041 Stray mem_ack in IDLE -> no done pulse and no state change; with ack at M and a waiting dma_req, dma_gnt at M+1 coincides with core_done.
